// File: rtl/mux_param_arb.sv
`timescale 1ns/1ps
// N-channel registered mux with valid/ready handshakes, fixed-select or round-robin grant.
// Define MUX_PARAM_ARB_CNT_EN to add the 16-bit output-transfer counter port out_count.
module mux_param_arb #(
  parameter int unsigned  WIDTH    = 2,
  parameter int unsigned  CHANNELS = 4,
  localparam int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_ch,
  output logic                      out_valid,
`ifdef MUX_PARAM_ARB_CNT_EN
  output logic [15:0]               out_count,
`endif
  input  logic                      out_ready
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_ch_q, out_ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic              load;
  logic              grant_vld;
  logic [SELW-1:0]   grant_ch;
  logic [SELW-1:0]   scan_ch;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= SELW'(CHANNELS - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

  // Grant decision, input handshake and next-state logic
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
    grant_vld  = 1'b0;
    grant_ch   = '0;
    scan_ch    = '0;
    in_ready   = '0;
    load       = (state_q == S_EMPTY) || out_ready;

    if (load) begin
      if (!mode) begin
        // Out-of-range select is rejected before indexing so no X reaches the grant
        if ((32'(sel) < CHANNELS) && in_valid[sel]) begin
          grant_vld = 1'b1;
          grant_ch  = sel;
        end
      end else begin
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
          scan_ch = SELW'((32'(ptr_q) + i) % CHANNELS);
          if (!grant_vld && in_valid[scan_ch]) begin
            grant_vld = 1'b1;
            grant_ch  = scan_ch;
          end
        end
      end
    end

    if (grant_vld && !rst) begin
      in_ready[grant_ch] = 1'b1;
    end

    if (grant_vld) begin
      state_d    = S_FULL;
      out_data_d = in_data[32'(grant_ch)*WIDTH +: WIDTH];
      out_ch_d   = grant_ch;
      if (mode) begin
        ptr_d = grant_ch;
      end
    end else if (load) begin
      state_d = S_EMPTY;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = (state_q == S_FULL);

`ifdef MUX_PARAM_ARB_CNT_EN
  logic [15:0] count_q, count_d;

  // Counts accepted output beats, wrapping at 16 bits
  always_comb begin
    count_d = count_q;
    if ((state_q == S_FULL) && out_ready) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_mux_param_arb.sv
`timescale 1ns/1ps
// Randomized self-checking bench for mux_param_arb (4-channel and 3-channel instances)
// against a queue-based scheduler model.
module tb_mux_param_arb;
  localparam int NCH = 4;
  localparam int W   = 2;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*W-1:0]  in_data;
  logic [NCH-1:0]    in_valid, in_ready;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid, out_ready;

  logic [5:0]        in_data3;
  logic [2:0]        in_valid3, in_ready3;
  logic              mode3;
  logic [1:0]        sel3;
  logic [1:0]        out_data3;
  logic [1:0]        out_ch3;
  logic              out_valid3, out_ready3;
`ifdef MUX_PARAM_ARB_CNT_EN
  logic [15:0]       out_count, out_count3;
`endif

  int                n_cmp = 0;
  int                n_err = 0;

  bit                m_valid;
  logic [W-1:0]      m_data;
  int                m_ch;
  int                m_ptr;
  logic [15:0]       m_count;

  always #5 clk = ~clk;

  mux_param_arb #(.WIDTH(W), .CHANNELS(NCH)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
`ifdef MUX_PARAM_ARB_CNT_EN
    .out_count(out_count),
`endif
    .out_ready(out_ready)
  );

  mux_param_arb #(.WIDTH(2), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
`ifdef MUX_PARAM_ARB_CNT_EN
    .out_count(out_count3),
`endif
    .out_ready(out_ready3)
  );

  // Scheduler model: returns granted channel or -1
  function automatic int model_grant();
    int order[$];
    if (m_valid && !out_ready) return -1;
    if (!mode) return (int'(sel) < NCH && in_valid[sel]) ? int'(sel) : -1;
    for (int i = 1; i <= NCH; i++) order.push_back((m_ptr + i) % NCH);
    foreach (order[j]) if (in_valid[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_ready(int g);
    logic [NCH-1:0] e = '0;
    if (g >= 0) e[g] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = NCH - 1; m_count = '0;
  endtask

  task automatic tick();
    int g;
    g = model_grant();
    if (m_valid && out_ready) m_count = m_count + 16'd1;
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1; m_data = in_data[g*W +: W]; m_ch = g;
      if (mode) m_ptr = g;
    end else if (!m_valid || out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_valid3 = '0;
    #1; @(posedge clk); #1;
    rst = 1'b0; model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; in_data = NCH*W'($urandom); mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid3 = '1; in_data3 = 6'($urandom); mode3 = 1'b1; sel3 = '0; out_ready3 = 1'b1;
    #1; @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (out_ch !== '0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_cmp++; if (in_ready3 !== '0) begin n_err++; $display("FAIL reset_in_ready3: got %b want 000", in_ready3); end
    rst = 1'b0; in_valid = '0; in_valid3 = '0; model_reset();
    #1; @(posedge clk); #1;
  endtask

  task automatic test_fixed();
    do_reset();
    in_data = NCH*W'($urandom); in_data[2*W +: W] = 2'b11;
    in_valid = 4'b0100; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 2'b11) begin n_err++; $display("FAIL fixed_data: got %b want 11", out_data); end
    n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL fixed_ch: got %0d want 2", out_ch); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fixed_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = NCH*W'($urandom);
      #1;
      n_cmp++; if (in_ready !== 4'(1 << seq[i])) begin n_err++; $display("FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << seq[i])); end
      tick();
      n_cmp++; if (out_ch !== SW'(seq[i]) || out_valid !== 1'b1) begin n_err++; $display("FAIL rr_seq[%0d]: got ch %0d valid %b want ch %0d valid 1", i, out_ch, out_valid, seq[i]); end
      n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rr_data[%0d]: got %b want %b", i, out_data, m_data); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_d;
    int held_c;
    held_d = m_data; held_c = m_ch;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = NCH*W'($urandom); in_valid = NCH'($urandom); mode = 1'($urandom); sel = SW'($urandom);
      #1;
      n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      n_cmp++; if (out_data !== held_d || out_ch !== SW'(held_c) || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got d %b ch %0d v %b want d %b ch %0d v 1", i, out_data, out_ch, out_valid, held_d, held_c); end
    end
    out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111; in_data = NCH*W'($urandom);
    #1;
    n_cmp++; if (in_ready !== exp_ready(model_grant()) || in_ready === '0) begin n_err++; $display("FAIL bp_release_ready: got %b want %b", in_ready, exp_ready(model_grant())); end
    tick();
    n_cmp++; if (out_ch !== SW'(m_ch) || out_data !== m_data || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_load: got ch %0d d %b want ch %0d d %b", out_ch, out_data, m_ch, m_data); end
  endtask

  task automatic test_rr_skip();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_data = NCH*W'($urandom);
    in_valid = 4'b0010; #1; tick();
    n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL skip_setup: got %0d want 1", out_ch); end
    in_valid = 4'b1010; #1; tick();
    n_cmp++; if (out_ch !== 2'd3) begin n_err++; $display("FAIL skip_ch3: got %0d want 3", out_ch); end
    tick();
    n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL skip_ch1: got %0d want 1", out_ch); end
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1110; #1;
    n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL nogrant_ready: got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nogrant_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_sel_out_of_range();
    int seq[4] = '{0, 1, 2, 0};
    do_reset();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = 6'($urandom);
    #1;
    n_cmp++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL oob_ready: got %b want 000", in_ready3); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL oob_valid: got %b want 0", out_valid3); end
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [5:0] d;
      in_data3 = 6'($urandom); d = in_data3; #1;
      @(posedge clk); #1;
      n_cmp++; if (out_ch3 !== 2'(seq[i]) || out_data3 !== d[seq[i]*2 +: 2]) begin n_err++; $display("FAIL rr3[%0d]: got ch %0d d %b want ch %0d d %b", i, out_ch3, out_data3, seq[i], d[seq[i]*2 +: 2]); end
    end
    mode3 = 1'b0; sel3 = 2'd3; #1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL oob_drain: got %b want 0", out_valid3); end
    in_valid3 = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1; in_data = NCH*W'($urandom); #1;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111; #1;
    rst = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_ch !== '0 || out_data !== '0) begin n_err++; $display("FAIL midrst_async: got v %b ch %0d d %b want 0 0 0", out_valid, out_ch, out_data); end
    n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL midrst_ready: got %b want 0000", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; model_reset(); out_ready = 1'b1; #1;
    tick();
    n_cmp++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_ptr: got ch %0d v %b want ch 0 v 1", out_ch, out_valid); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_data = NCH*W'($urandom); in_valid = NCH'($urandom);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = SW'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant();
      n_cmp++; if (in_ready !== exp_ready(g)) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_ready(g)); end
      tick();
      n_cmp++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (out_data !== m_data || out_ch !== SW'(m_ch)) begin n_err++; $display("FAIL rand_out[%0d]: got d %b ch %0d want d %b ch %0d", i, out_data, out_ch, m_data, m_ch); end
      end
`ifdef MUX_PARAM_ARB_CNT_EN
      n_cmp++; if (out_count !== m_count) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, out_count, m_count); end
`endif
    end
  endtask

`ifdef MUX_PARAM_ARB_CNT_EN
  task automatic test_count_wrap();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    repeat (65538) @(posedge clk);
    #1;
    n_cmp++; if (out_count !== 16'd1) begin n_err++; $display("FAIL count_wrap: got %0d want 1", out_count); end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_rr_skip();
    test_sel_out_of_range();
    test_reset_mid();
    test_random();
`ifdef MUX_PARAM_ARB_CNT_EN
    test_count_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
